// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and default widths for the instruction-cache refill controller.
package icache_refill_ctrl_pkg;

  localparam int ICACHE_ADDR_W = 32;
  localparam int ICACHE_DATA_W = 32;
  localparam int ICACHE_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } state_e;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Fetch-side cache sequencer: one-cycle hits, single outstanding word refill
// on a miss, and flush handling that lets an in-flight refill complete silently.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = ICACHE_ADDR_W,
  parameter int DATA_W = ICACHE_DATA_W
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    fetch_valid,
  input  logic [ADDR_W-1:0]       fetch_pc,
  output logic                    fetch_ready,
  output logic                    inst_valid,
  output logic [DATA_W-1:0]       inst_data,
  output logic [ADDR_W-1:0]       inst_pc,
  input  logic                    dec_ready,
  output logic [ADDR_W-1:0]       icache_addr,
  input  logic                    icache_hit,
  input  logic [DATA_W-1:0]       icache_rdata,
  output logic                    icache_we,
  output logic                    icache_block,
  output logic [DATA_W-1:0]       icache_wdata,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_done,
  input  logic [DATA_W-1:0]       mem_data,
  output logic [ICACHE_CNT_W-1:0] miss_count
);

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       miss_pc_q, miss_pc_d;
  logic [DATA_W-1:0]       fill_data_q, fill_data_d;
  logic                    drop_q, drop_d;
  logic                    inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0]       inst_data_q, inst_data_d;
  logic [ADDR_W-1:0]       inst_pc_q, inst_pc_d;
  logic [ICACHE_CNT_W-1:0] miss_count_q, miss_count_d;

  logic [ADDR_W-1:0]       fetch_pc_al;
  logic                    load;
  logic [DATA_W-1:0]       load_data;
  logic [ADDR_W-1:0]       load_pc;

  assign fetch_pc_al = fetch_pc & WORD_MASK;

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_d      = state_q;
    miss_pc_d    = miss_pc_q;
    fill_data_d  = fill_data_q;
    drop_d       = drop_q;
    miss_count_d = miss_count_q;
    fetch_ready  = 1'b0;
    mem_req      = 1'b0;
    icache_we    = 1'b0;
    icache_addr  = miss_pc_q;
    load         = 1'b0;
    load_data    = icache_rdata;
    load_pc      = fetch_pc_al;

    case (state_q)
      ST_IDLE: begin
        icache_addr = fetch_pc_al;
        // Gated by rdy_in so a frozen block never completes a handshake.
        fetch_ready = rdy_in && !flush_in && (!inst_valid_q || dec_ready);
        if (fetch_valid && fetch_ready) begin
          if (icache_hit) begin
            load = 1'b1;
          end else begin
            miss_pc_d    = fetch_pc_al;
            miss_count_d = miss_count_q + 1'b1;
            state_d      = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (flush_in) drop_d = 1'b1;
        if (mem_done) begin
          fill_data_d = mem_data;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        // The cache is written even for a dropped refill: the word is valid
        // for its address regardless of the redirect.
        icache_we = 1'b1;
        load      = !drop_q && !flush_in;
        load_data = fill_data_q;
        load_pc   = miss_pc_q;
        drop_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    if (flush_in) begin
      inst_valid_d = 1'b0;
    end else if (load) begin
      inst_valid_d = 1'b1;
      inst_data_d  = load_data;
      inst_pc_d    = load_pc;
    end else if (dec_ready) begin
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      miss_pc_q    <= '0;
      fill_data_q  <= '0;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
      miss_count_q <= '0;
    end else if (rdy_in) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      miss_pc_q    <= miss_pc_d;
      fill_data_q  <= fill_data_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign inst_valid   = inst_valid_q;
  assign inst_data    = inst_data_q;
  assign inst_pc      = inst_pc_q;
  assign icache_block = icache_we;
  assign icache_wdata = fill_data_q;
  assign mem_addr     = miss_pc_q;
  assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed scenarios plus a randomized phase scored against a transaction-level
// model: a word-indexed cache, a fixed memory image and an in-order fetch queue.
module tb_icache_refill_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          rdy_in = 1'b1;
  logic          flush_in = 1'b0;
  logic          fetch_valid = 1'b0;
  logic [AW-1:0] fetch_pc = '0;
  logic          fetch_ready;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          dec_ready = 1'b1;
  logic [AW-1:0] icache_addr;
  logic          icache_hit = 1'b0;
  logic [DW-1:0] icache_rdata = '0;
  logic          icache_we;
  logic          icache_block;
  logic [DW-1:0] icache_wdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_done = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic [31:0]   miss_count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bit          cache_has [16];
  logic [31:0] exp_q [$];
  int          exp_misses = 0;
  logic [31:0] miss_pc_exp = '0;
  bit          req_active = 1'b0;
  bit          mem_hold = 1'b0;
  int          mem_wait = 0;

  icache_refill_ctrl dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .flush_in    (flush_in),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .dec_ready   (dec_ready),
    .icache_addr (icache_addr),
    .icache_hit  (icache_hit),
    .icache_rdata(icache_rdata),
    .icache_we   (icache_we),
    .icache_block(icache_block),
    .icache_wdata(icache_wdata),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_done    (mem_done),
    .mem_data    (mem_data),
    .miss_count  (miss_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2) & 15;
  endfunction

  // One cycle of the self-driving environment; rnd=0 gives a quiet drain cycle.
  task automatic env_cycle(input bit rnd);
    logic [31:0] pc_al;
    bit          in_range;
    if (rnd) begin
      rdy_in      = ($urandom_range(9) != 0);
      flush_in    = ($urandom_range(39) == 0);
      dec_ready   = ($urandom_range(3) != 0);
      fetch_valid = $urandom_range(1);
      fetch_pc    = BASE + ($urandom_range(15) << 2) + $urandom_range(3);
    end else begin
      rdy_in = 1'b1; flush_in = 1'b0; dec_ready = 1'b1; fetch_valid = 1'b0;
    end
    if (!mem_hold) mem_done = 1'b0;
    #1;
    in_range     = (icache_addr >= BASE) && (icache_addr < BASE + 32'd64);
    icache_hit   = in_range && cache_has[word_idx(icache_addr)];
    icache_rdata = mem_word(icache_addr);
    if (mem_req && !mem_done) begin
      if (!req_active) begin
        req_active = 1'b1;
        mem_wait   = $urandom_range(4);
      end
      if (mem_wait == 0) begin
        mem_done = 1'b1;
        mem_data = mem_word(mem_addr);
      end else begin
        mem_wait--;
      end
    end
    #1;
    check("block_eq_we", icache_block, icache_we);
    if (icache_we) check("refill_wdata", icache_wdata, mem_word(icache_addr));
    if (mem_req) begin
      check("single_outstanding", fetch_ready, 1'b0);
      check("mem_addr", mem_addr, miss_pc_exp);
    end
    if (rdy_in) begin
      if (flush_in) begin
        check("flush_no_accept", fetch_ready, 1'b0);
        exp_q.delete();
      end else begin
        if (inst_valid) check("valid_has_expect", exp_q.size() != 0, 1'b1);
        if (inst_valid && dec_ready && exp_q.size() != 0) begin
          pc_al = exp_q.pop_front();
          check("rand_inst_pc", inst_pc, pc_al);
          check("rand_inst_data", inst_data, mem_word(pc_al));
        end
        if (fetch_valid && fetch_ready) begin
          pc_al = fetch_pc & ~32'd3;
          check("lookup_addr", icache_addr, pc_al);
          exp_q.push_back(pc_al);
          if (!cache_has[word_idx(pc_al)]) begin
            exp_misses++;
            miss_pc_exp = pc_al;
          end
        end
      end
      if (icache_we) cache_has[word_idx(icache_addr)] = 1'b1;
      if (mem_done) req_active = 1'b0;
      mem_hold = 1'b0;
    end else begin
      mem_hold = mem_done;
    end
    tick();
  endtask

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_icache_we", icache_we, 1'b0);
    check("rst_miss_count", miss_count, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    rst_in = 1'b0;
    tick();

    // ---------------- cold miss ----------------
    fetch_valid = 1'b1; fetch_pc = 32'h1000; icache_hit = 1'b0;
    #1;
    check("cold_fetch_ready", fetch_ready, 1'b1);
    check("cold_lookup", icache_addr, 32'h1000);
    tick();
    fetch_valid = 1'b0;
    check("cold_miss_count", miss_count, 32'd1);
    check("cold_fetch_busy", fetch_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("cold_mem_req", mem_req, 1'b1);
      check("cold_mem_addr", mem_addr, 32'h1000);
      check("cold_no_we", icache_we, 1'b0);
      tick();
    end
    check("cold_mem_req5", mem_req, 1'b1);
    mem_done = 1'b1; mem_data = 32'h0050_0093;
    tick();
    mem_done = 1'b0;
    check("cold_req_drop", mem_req, 1'b0);
    check("cold_we", icache_we, 1'b1);
    check("cold_block", icache_block, 1'b1);
    check("cold_waddr", icache_addr, 32'h1000);
    check("cold_wdata", icache_wdata, 32'h0050_0093);
    check("cold_not_yet_valid", inst_valid, 1'b0);
    tick();
    check("cold_valid", inst_valid, 1'b1);
    check("cold_pc", inst_pc, 32'h1000);
    check("cold_data", inst_data, 32'h0050_0093);
    check("cold_we_once", icache_we, 1'b0);
    tick();
    check("cold_consumed", inst_valid, 1'b0);

    // ---------------- hit stream (second PC misaligned) ----------------
    fetch_valid = 1'b1; icache_hit = 1'b1;
    fetch_pc = 32'h0; icache_rdata = 32'hA000_0000;
    tick();
    check("hit0_valid", inst_valid, 1'b1);
    check("hit0_pc", inst_pc, 32'h0);
    check("hit0_data", inst_data, 32'hA000_0000);
    fetch_pc = 32'h7; icache_rdata = 32'hA000_0004;
    #1;
    check("hit_b2b_ready", fetch_ready, 1'b1);
    tick();
    check("hit1_pc", inst_pc, 32'h4);
    check("hit1_data", inst_data, 32'hA000_0004);
    check("hit1_no_mem", mem_req, 1'b0);
    fetch_pc = 32'h8; icache_rdata = 32'hA000_0008;
    tick();
    fetch_valid = 1'b0;
    check("hit2_valid", inst_valid, 1'b1);
    check("hit2_pc", inst_pc, 32'h8);
    check("hit2_data", inst_data, 32'hA000_0008);
    check("hit_miss_count", miss_count, 32'd1);
    tick();
    check("hit_drained", inst_valid, 1'b0);

    // ---------------- decoder stall ----------------
    fetch_valid = 1'b1; fetch_pc = 32'h20; icache_rdata = 32'hB000_0020;
    tick();
    fetch_pc = 32'h24; icache_rdata = 32'hB000_0024; dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid", inst_valid, 1'b1);
      check("stall_pc", inst_pc, 32'h20);
      check("stall_data", inst_data, 32'hB000_0020);
      check("stall_not_ready", fetch_ready, 1'b0);
      tick();
    end
    dec_ready = 1'b1;
    #1;
    check("stall_release_ready", fetch_ready, 1'b1);
    tick();
    fetch_valid = 1'b0;
    check("stall_next_pc", inst_pc, 32'h24);
    check("stall_next_data", inst_data, 32'hB000_0024);
    tick();
    check("stall_drained", inst_valid, 1'b0);

    // ---------------- flush mid-refill ----------------
    fetch_valid = 1'b1; fetch_pc = 32'h40; icache_hit = 1'b0;
    tick();
    fetch_valid = 1'b0;
    tick();
    flush_in = 1'b1;
    #1;
    check("flush_req_held", mem_req, 1'b1);
    tick();
    flush_in = 1'b0;
    check("flush_req_after", mem_req, 1'b1);
    check("flush_addr", mem_addr, 32'h40);
    tick();
    mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    mem_done = 1'b0;
    check("flush_fill_we", icache_we, 1'b1);
    check("flush_fill_wdata", icache_wdata, 32'hDEAD_BEEF);
    check("flush_fill_busy", fetch_ready, 1'b0);
    tick();
    check("flush_no_inst", inst_valid, 1'b0);
    check("flush_ready_after", fetch_ready, 1'b1);
    check("flush_miss_count", miss_count, 32'd2);

    // ---------------- mem_done together with flush ----------------
    fetch_valid = 1'b1; fetch_pc = 32'h60;
    tick();
    fetch_valid = 1'b0;
    mem_done = 1'b1; mem_data = 32'h1234_5678; flush_in = 1'b1;
    tick();
    mem_done = 1'b0; flush_in = 1'b0;
    check("coinc_fill_we", icache_we, 1'b1);
    check("coinc_wdata", icache_wdata, 32'h1234_5678);
    tick();
    check("coinc_no_inst", inst_valid, 1'b0);

    // ---------------- rdy_in pause during REQ ----------------
    fetch_valid = 1'b1; fetch_pc = 32'h200;
    tick();
    fetch_valid = 1'b0;
    tick();
    rdy_in = 1'b0; mem_done = 1'b1; mem_data = 32'hCAFE_0200;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pause_req", mem_req, 1'b1);
      check("pause_no_fill", icache_we, 1'b0);
      check("pause_count", miss_count, 32'd4);
    end
    rdy_in = 1'b1;
    tick();
    mem_done = 1'b0;
    check("pause_fill_we", icache_we, 1'b1);
    check("pause_fill_wdata", icache_wdata, 32'hCAFE_0200);
    tick();
    check("pause_valid", inst_valid, 1'b1);
    check("pause_pc", inst_pc, 32'h200);
    tick();

    // ---------------- async reset during FILL ----------------
    fetch_valid = 1'b1; fetch_pc = 32'h300;
    tick();
    fetch_valid = 1'b0;
    mem_done = 1'b1; mem_data = 32'h0BAD_0300;
    tick();
    mem_done = 1'b0;
    check("ar_fill_we", icache_we, 1'b1);
    check("ar_count_before", miss_count, 32'd5);
    #2 rst_in = 1'b1;
    #1;
    check("ar_we", icache_we, 1'b0);
    check("ar_mem_req", mem_req, 1'b0);
    check("ar_inst_valid", inst_valid, 1'b0);
    check("ar_inst_pc", inst_pc, 32'd0);
    check("ar_inst_data", inst_data, 32'd0);
    check("ar_miss_count", miss_count, 32'd0);
    tick();
    rst_in = 1'b0;
    tick();
    check("ar_idle_ready", fetch_ready, 1'b1);

    // ---------------- randomized phase ----------------
    for (int i = 0; i < 16; i++) cache_has[i] = bit'($urandom_range(1));
    for (int i = 0; i < 3000; i++) env_cycle(1'b1);
    for (int i = 0; i < 60; i++) env_cycle(1'b0);
    check("rand_queue_drained", exp_q.size(), 0);
    check("rand_miss_count", miss_count, exp_misses);
    check("rand_idle_mem", mem_req, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
